// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate, WB_PORTS writebacks, dual in-order retire, partial flush.
// Optional precise-exception support is enabled by defining ROB_EXCEPTION_EN.
module rob_multiport #(
   parameter int DEPTH    = 32,
   parameter int TAG_W    = 5,
   parameter int DATA_W   = 32,
   parameter int REG_W    = 5,
   parameter int WB_PORTS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue,
   input  logic [REG_W-1:0]             issue_dest,
   input  logic                         issue_store,
   output logic                         issue_ready,
   output logic [TAG_W-1:0]             issue_tag,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
   input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
`ifdef ROB_EXCEPTION_EN
   input  logic [WB_PORTS-1:0]          wb_exc,
   output logic                         exc_valid,
   output logic [TAG_W-1:0]             exc_tag,
`endif
   input  logic                         flush,
   input  logic [TAG_W-1:0]             flush_tag,
   input  logic                         st_ready,
   output logic [1:0]                   commit_valid,
   output logic [1:0]                   commit_store,
   output logic [REG_W-1:0]             commit_addr0,
   output logic [REG_W-1:0]             commit_addr1,
   output logic [DATA_W-1:0]            commit_val0,
   output logic [DATA_W-1:0]            commit_val1,
   output logic [TAG_W:0]               count
);

   logic [TAG_W-1:0]  head, tail, head1, head_n, tail_n;
   logic [TAG_W:0]    count_n, keep_cnt;
   logic [DEPTH-1:0]  ready_q, ready_n, store_q, store_n;
   logic [REG_W-1:0]  dest_q  [DEPTH];
   logic [REG_W-1:0]  dest_n  [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_n [DEPTH];
   logic              ret0, ret1, issue_acc, exc_take;
`ifdef ROB_EXCEPTION_EN
   logic [DEPTH-1:0]  exc_q, exc_n;
`endif

   // Age of a slot relative to head; a slot is live when its age is below the live count.
   function automatic logic [TAG_W:0] age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
      return {1'b0, t - h};
   endfunction

   assign head1       = head + TAG_W'(1);
   assign issue_ready = (count != (TAG_W+1)'(DEPTH));
   assign issue_tag   = tail;

`ifdef ROB_EXCEPTION_EN
   assign exc_take = !flush && (count != '0) && ready_q[head] && exc_q[head];
`else
   assign exc_take = 1'b0;
`endif

   always_comb begin : ctl
      ret0 = !flush && !exc_take && (count != '0) && ready_q[head]
             && (!store_q[head] || st_ready);
      ret1 = ret0 && (count > (TAG_W+1)'(1)) && ready_q[head1]
             && !(store_q[head] && store_q[head1]) && (!store_q[head1] || st_ready);
      issue_acc = issue && issue_ready && !flush && !exc_take;
      keep_cnt  = flush ? age(flush_tag, head) + (TAG_W+1)'(1) : count;
   end

   always_comb begin : nxt
      ready_n = ready_q;
      store_n = store_q;
      dest_n  = dest_q;
      value_n = value_q;
`ifdef ROB_EXCEPTION_EN
      exc_n   = exc_q;
`endif
      // Ascending port order lets the highest port win on a shared tag.
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && (age(wb_tag[p*TAG_W +: TAG_W], head) < keep_cnt)) begin
            ready_n[wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            value_n[wb_tag[p*TAG_W +: TAG_W]] = wb_value[p*DATA_W +: DATA_W];
`ifdef ROB_EXCEPTION_EN
            exc_n[wb_tag[p*TAG_W +: TAG_W]]   = wb_exc[p];
`endif
         end
      end
      if (ret0) ready_n[head]  = 1'b0;
      if (ret1) ready_n[head1] = 1'b0;
      if (flush) begin
         for (int unsigned e = 0; e < DEPTH; e++) begin
            if (age(TAG_W'(e), head) >= keep_cnt) ready_n[e] = 1'b0;
         end
      end
      if (exc_take) ready_n = '0;
      if (issue_acc) begin
         dest_n[tail]  = issue_dest;
         store_n[tail] = issue_store;
         ready_n[tail] = 1'b0;
`ifdef ROB_EXCEPTION_EN
         exc_n[tail]   = 1'b0;
`endif
      end
      head_n = exc_take ? tail : head + TAG_W'(ret0) + TAG_W'(ret1);
      tail_n = flush ? flush_tag + TAG_W'(1) : tail + TAG_W'(issue_acc);
      if (flush)         count_n = keep_cnt;
      else if (exc_take) count_n = '0;
      else               count_n = count + (TAG_W+1)'(issue_acc)
                                   - (TAG_W+1)'(ret0) - (TAG_W+1)'(ret1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         ready_q      <= '0;
         store_q      <= '0;
         commit_valid <= '0;
         commit_store <= '0;
         commit_addr0 <= '0;
         commit_addr1 <= '0;
         commit_val0  <= '0;
         commit_val1  <= '0;
         for (int unsigned e = 0; e < DEPTH; e++) begin
            dest_q[e]  <= '0;
            value_q[e] <= '0;
         end
`ifdef ROB_EXCEPTION_EN
         exc_q        <= '0;
         exc_valid    <= 1'b0;
         exc_tag      <= '0;
`endif
      end else begin
         head         <= head_n;
         tail         <= tail_n;
         count        <= count_n;
         ready_q      <= ready_n;
         store_q      <= store_n;
         dest_q       <= dest_n;
         value_q      <= value_n;
         commit_valid <= {ret1, ret0};
         commit_store <= {ret1 & store_q[head1], ret0 & store_q[head]};
         commit_addr0 <= ret0 ? dest_q[head]   : '0;
         commit_addr1 <= ret1 ? dest_q[head1]  : '0;
         commit_val0  <= ret0 ? value_q[head]  : '0;
         commit_val1  <= ret1 ? value_q[head1] : '0;
`ifdef ROB_EXCEPTION_EN
         exc_q        <= exc_n;
         exc_valid    <= exc_take;
         exc_tag      <= exc_take ? head : '0;
`endif
      end
   end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: queue-based reference model, directed scenarios, then randomized traffic.
module tb_rob_multiport;
   localparam int DEPTH = 32, TAG_W = 5, DATA_W = 32, REG_W = 5, WB_PORTS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic issue = 1'b0, issue_store = 1'b0, flush = 1'b0, st_ready = 1'b1;
   logic [REG_W-1:0]           issue_dest = '0;
   logic [WB_PORTS-1:0]        wb_valid = '0;
   logic [WB_PORTS*TAG_W-1:0]  wb_tag = '0;
   logic [WB_PORTS*DATA_W-1:0] wb_value = '0;
   logic [TAG_W-1:0]           flush_tag = '0;
   logic                       issue_ready;
   logic [TAG_W-1:0]           issue_tag;
   logic [1:0]                 commit_valid, commit_store;
   logic [REG_W-1:0]           commit_addr0, commit_addr1;
   logic [DATA_W-1:0]          commit_val0, commit_val1;
   logic [TAG_W:0]             count;
`ifdef ROB_EXCEPTION_EN
   logic [WB_PORTS-1:0]        wb_exc = '0;
   logic                       exc_valid;
   logic [TAG_W-1:0]           exc_tag;
`endif

   always #5 clk = ~clk;

   rob_multiport #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .WB_PORTS(WB_PORTS)) dut (
      .clk(clk), .rst(rst), .issue(issue), .issue_dest(issue_dest), .issue_store(issue_store),
      .issue_ready(issue_ready), .issue_tag(issue_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
      .wb_value(wb_value),
`ifdef ROB_EXCEPTION_EN
      .wb_exc(wb_exc), .exc_valid(exc_valid), .exc_tag(exc_tag),
`endif
      .flush(flush), .flush_tag(flush_tag), .st_ready(st_ready), .commit_valid(commit_valid),
      .commit_store(commit_store), .commit_addr0(commit_addr0), .commit_addr1(commit_addr1),
      .commit_val0(commit_val0), .commit_val1(commit_val1), .count(count));

   // Reference model: program-ordered list of in-flight instructions.
   typedef struct {
      logic [REG_W-1:0]  dest;
      logic              st;
      logic              rdy;
      logic [DATA_W-1:0] val;
   } ent_t;
   ent_t q[$];
   int unsigned mh = 0;
   logic [1:0]        e_cv = '0, e_cs = '0;
   logic [REG_W-1:0]  e_a [2];
   logic [DATA_W-1:0] e_v [2];
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int unsigned sz = q.size();
      int unsigned n = 0;
      int unsigned keep = sz;
      int unsigned idx;
      ent_t e;
      if (!flush && sz >= 1 && q[0].rdy && (!q[0].st || st_ready)) n = 1;
      if (n == 1 && sz >= 2 && q[1].rdy && !(q[0].st && q[1].st) && (!q[1].st || st_ready)) n = 2;
      e_cv = '0;
      e_cs = '0;
      for (int k = 0; k < int'(n); k++) begin
         e_cv[k] = 1'b1;
         e_cs[k] = q[k].st;
         e_a[k]  = q[k].dest;
         e_v[k]  = q[k].val;
      end
      if (flush) keep = (int'(flush_tag) + DEPTH - mh) % DEPTH + 1;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p]) begin
            idx = (int'(wb_tag[p*TAG_W +: TAG_W]) + DEPTH - mh) % DEPTH;
            if (idx < keep) begin
               e = q[idx];
               e.rdy = 1'b1;
               e.val = wb_value[p*DATA_W +: DATA_W];
               q[idx] = e;
            end
         end
      end
      if (flush) begin
         while (q.size() > keep) void'(q.pop_back());
      end else begin
         for (int k = 0; k < int'(n); k++) void'(q.pop_front());
         mh = (mh + n) % DEPTH;
         if (issue && sz < DEPTH) begin
            e.dest = issue_dest; e.st = issue_store; e.rdy = 1'b0; e.val = '0;
            q.push_back(e);
         end
      end
   endtask

   task automatic check_all();
      chk("commit_valid", 64'(commit_valid), 64'(e_cv));
      chk("commit_store", 64'(commit_store), 64'(e_cs));
      if (e_cv[0]) begin
         chk("commit_addr0", 64'(commit_addr0), 64'(e_a[0]));
         chk("commit_val0", 64'(commit_val0), 64'(e_v[0]));
      end
      if (e_cv[1]) begin
         chk("commit_addr1", 64'(commit_addr1), 64'(e_a[1]));
         chk("commit_val1", 64'(commit_val1), 64'(e_v[1]));
      end
      chk("count", 64'(count), 64'(q.size()));
      chk("issue_ready", 64'(issue_ready), 64'(q.size() < DEPTH));
      chk("issue_tag", 64'(issue_tag), 64'((mh + q.size()) % DEPTH));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      issue = 1'b0; wb_valid = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      q.delete(); mh = 0; e_cv = '0; e_cs = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      check_all();
   endtask

   task automatic set_wb(input int p, input int unsigned t, input logic [DATA_W-1:0] v);
      wb_valid[p] = 1'b1;
      wb_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
      wb_value[p*DATA_W +: DATA_W] = v;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd1);
      chk("rst_issue_tag", 64'(issue_tag), 64'd0);
      chk("rst_commit_valid", 64'(commit_valid), 64'd0);
      chk("rst_commit_addr0", 64'(commit_addr0), 64'd0);
      chk("rst_commit_val0", 64'(commit_val0), 64'd0);
      check_all();

      // Fill: 33 back-to-back issues, the last must be dropped
      for (int i = 0; i < 33; i++) begin
         if (i < 32) chk("fill_tag", 64'(issue_tag), 64'(i));
         issue = 1'b1; issue_dest = REG_W'(i);
         cycle();
      end
      chk("full_count", 64'(count), 64'd32);
      chk("full_ready", 64'(issue_ready), 64'd0);
      do_reset();

      // Out-of-order writeback, dual retire
      issue = 1'b1; issue_dest = 5'd3; cycle();
      issue = 1'b1; issue_dest = 5'd7; cycle();
      set_wb(0, 1, 32'hAA); cycle();
      set_wb(2, 0, 32'hBB); cycle();
      cycle();
      chk("dual_cv", 64'(commit_valid), 64'h3);
      chk("dual_a0", 64'(commit_addr0), 64'd3);
      chk("dual_a1", 64'(commit_addr1), 64'd7);
      chk("dual_v0", 64'(commit_val0), 64'hBB);
      chk("dual_v1", 64'(commit_val1), 64'hAA);
      cycle();
      do_reset();

      // Two stores held by st_ready, then one per cycle
      st_ready = 1'b0;
      issue = 1'b1; issue_store = 1'b1; issue_dest = 5'd1; cycle();
      issue = 1'b1; issue_store = 1'b1; issue_dest = 5'd2; cycle();
      issue_store = 1'b0;
      set_wb(0, 0, 32'h10); set_wb(1, 1, 32'h11); cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("st_hold", 64'(commit_valid), 64'd0);
      end
      st_ready = 1'b1;
      cycle(); chk("st_first", 64'({commit_valid, commit_store}), 64'h5);
      cycle(); chk("st_second", 64'({commit_valid, commit_store, commit_addr0}), 64'({4'h5, 5'd2}));
      cycle(); chk("st_empty", 64'(count), 64'd0);
      do_reset();

      // Partial flush with simultaneous writebacks on kept and squashed entries
      for (int i = 0; i < 10; i++) begin
         issue = 1'b1; issue_dest = REG_W'(i); cycle();
      end
      set_wb(0, 3, 32'h33); set_wb(1, 7, 32'h77);
      flush = 1'b1; flush_tag = 5'd4; issue = 1'b1;
      cycle();
      chk("flush_count", 64'(count), 64'd5);
      chk("flush_tail", 64'(issue_tag), 64'd5);
      set_wb(0, 0, 32'd100); set_wb(1, 1, 32'd101); set_wb(2, 2, 32'd102); set_wb(3, 4, 32'd104);
      cycle();
      cycle(); chk("fl_c01", 64'(commit_valid), 64'h3);
      cycle(); chk("fl_tag3", 64'({commit_valid, commit_addr1, commit_val1}), 64'({2'h3, 5'd3, 32'h33}));
      cycle(); chk("fl_tag4", 64'({commit_valid, commit_addr0}), 64'({2'h1, 5'd4}));
      do_reset();

      // Walk head to 31, then dual retire across the wrap
      for (int i = 0; i < 31; i++) begin
         issue = 1'b1; issue_dest = REG_W'(i); cycle();
      end
      for (int b = 0; b < 31; b += 4) begin
         for (int p = 0; p < 4; p++) if (b + p < 31) set_wb(p, b + p, 32'(b + p));
         cycle();
      end
      repeat (16) cycle();
      chk("wrap_head31", 64'(issue_tag), 64'd31);
      issue = 1'b1; issue_dest = 5'd9;  cycle();
      issue = 1'b1; issue_dest = 5'd10; cycle();
      set_wb(0, 31, 32'h3131); set_wb(1, 0, 32'h0); cycle();
      cycle();
      chk("wrap_cv", 64'({commit_valid, commit_addr0, commit_addr1}), 64'({2'h3, 5'd9, 5'd10}));
      chk("wrap_count", 64'(count), 64'd0);
      chk("wrap_tail", 64'(issue_tag), 64'd1);
      do_reset();

      // Randomized traffic, alternating fill-heavy and drain-heavy phases
      for (int c = 0; c < 4000; c++) begin
         int unsigned sz = q.size();
         st_ready    = ($urandom_range(0, 3) != 0);
         issue       = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         issue_dest  = REG_W'($urandom);
         issue_store = ($urandom_range(0, 3) == 0);
         for (int p = 0; p < WB_PORTS; p++) begin
            if ($urandom_range(0, 2) == 0) begin
               if (sz > 0 && $urandom_range(0, 7) != 0) set_wb(p, (mh + $urandom_range(0, sz - 1)) % DEPTH, $urandom);
               else set_wb(p, $urandom_range(0, DEPTH - 1), $urandom);
            end
         end
         if (sz > 0 && $urandom_range(0, 39) == 0) begin
            flush = 1'b1;
            flush_tag = TAG_W'((mh + $urandom_range(0, sz - 1)) % DEPTH);
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
